// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, fetch state encoding, NOP word
// and the IF/ID entry layout used by the fetch stage and its skid buffer.
package mips_pkg;
  localparam int XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} fetchState_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcPlus4;
  } fetchEntry_t;

  // j target: upper nibble of the delay-slot PC with the 26-bit word index
  function automatic logic [XLEN-1:0] jumpTarget(input logic [XLEN-1:0] pcPlus4,
                                                 input logic [XLEN-1:0] instr);
    return {pcPlus4[31:28], instr[25:0], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pcPlus4} buffer catching a fetch that completes while
// the pipeline is stalled. clear beats load, load beats unload.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rstN,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] inInstr,
  input  logic [XLEN-1:0] inPcPlus4,
  output logic [XLEN-1:0] outInstr,
  output logic [XLEN-1:0] outPcPlus4,
  output logic            full
);
  fetchEntry_t entry;

  assign outInstr   = entry.instr;
  assign outPcPlus4 = entry.pcPlus4;

  // capture / drain the single entry
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      entry <= '0;
      full  <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      entry <= '{instr: inInstr, pcPlus4: inPcPlus4};
      full  <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS IF stage: PC, imem valid/ready fetch, IF/ID register, skid buffer,
// redirect with wrong-path squash. Optional macro JUMP_EN lets the unit
// resolve j itself from the IF/ID instruction.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        stall,
  input  logic        pcSrc,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemRdata,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPcPlus4,
  output logic        ifidValid
);
  fetchState_e state;
  logic [XLEN-1:0] pc, discAddr, pcPlus4, redirTarget, newPc;
  logic [XLEN-1:0] bufInstr, bufPcPlus4;
  logic xfer, jumpReq, redirect, bufFull, bufLoad, bufUnload;

`ifdef JUMP_EN
  assign jumpReq     = ifidValid & ~pcSrc & (ifidInstr[31:26] == OP_J);
  assign redirTarget = pcSrc ? branchTarget : jumpTarget(ifidPcPlus4, ifidInstr);
`else
  assign jumpReq     = 1'b0;
  assign redirTarget = branchTarget;
`endif

  // stall masks any redirect; it is re-presented once the hazard clears
  assign redirect  = (pcSrc | jumpReq) & ~stall;
  assign newPc     = redirTarget & ~32'h3;
  assign pcPlus4   = pc + 32'd4;
  assign imemReq   = (state == FETCH) | (state == DISCARD);
  assign imemAddr  = (state == DISCARD) ? discAddr : pc;
  assign xfer      = imemReq & imemValid;
  assign bufLoad   = (state == FETCH) & xfer & stall;
  assign bufUnload = (state == HOLD) & ~stall;

  fetch_skid_buf uSkid (
    .clk        (clk),
    .rstN       (rstN),
    .load       (bufLoad),
    .unload     (bufUnload),
    .clear      (redirect),
    .inInstr    (imemRdata),
    .inPcPlus4  (pcPlus4),
    .outInstr   (bufInstr),
    .outPcPlus4 (bufPcPlus4),
    .full       (bufFull)
  );

  // fetch FSM, PC and IF/ID register; redirect > stall > advance
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      discAddr    <= RESET_PC;
      ifidInstr   <= NOP_INSTR;
      ifidPcPlus4 <= '0;
      ifidValid   <= 1'b0;
    end else if (redirect) begin
      pc          <= newPc;
      ifidInstr   <= NOP_INSTR;
      ifidPcPlus4 <= '0;
      ifidValid   <= 1'b0;
      case (state)
        // request already on the bus must complete before the new one
        FETCH:   if (xfer) state <= FETCH;
                 else begin discAddr <= pc; state <= DISCARD; end
        DISCARD: if (xfer) state <= FETCH;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (xfer) begin
            pc <= pcPlus4;
            if (stall) state <= HOLD;
            else begin
              ifidInstr   <= imemRdata;
              ifidPcPlus4 <= pcPlus4;
              ifidValid   <= 1'b1;
            end
          end else if (!stall) begin
            ifidInstr   <= NOP_INSTR;
            ifidPcPlus4 <= '0;
            ifidValid   <= 1'b0;
          end
        end
        HOLD: if (!stall) begin
          ifidInstr   <= bufInstr;
          ifidPcPlus4 <= bufPcPlus4;
          ifidValid   <= bufFull;
          state       <= FETCH;
        end
        DISCARD: begin
          if (xfer) state <= FETCH;
          if (!stall) begin
            ifidInstr   <= NOP_INSTR;
            ifidPcPlus4 <= '0;
            ifidValid   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory returning the address
// as data (one j word planted), scoreboard on the IF/ID stream, redirect
// vector table, hand sequences for latency/stall/squash/reset/jump.
module tb_instr_fetch_unit;
  localparam logic [31:0] J_ADDR = 32'h1000_0004;
  localparam logic [31:0] J_WORD = 32'h0800_0040;

  logic        clk = 1'b0;
  logic        rstN, stall, pcSrc;
  logic [31:0] branchTarget;
  logic        imemReq, imemValid;
  logic [31:0] imemAddr, imemRdata;
  logic [31:0] ifidInstr, ifidPcPlus4;
  logic        ifidValid;

  int nCmp = 0, nFail = 0;
  int lat = 0, waitCnt = 0;
  logic monEn = 1'b0;

  typedef struct packed { logic [31:0] instr; logic [31:0] pcPlus4; } exp_t;
  exp_t sbQ[$];

  typedef struct {
    logic [31:0] target;
    logic [31:0] expBase;
    int          lat;
    int          count;
  } vec_t;
  vec_t vecs[5];

  instr_fetch_unit dut (
    .clk(clk), .rstN(rstN), .stall(stall), .pcSrc(pcSrc),
    .branchTarget(branchTarget), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemRdata(imemRdata), .ifidInstr(ifidInstr),
    .ifidPcPlus4(ifidPcPlus4), .ifidValid(ifidValid)
  );

  always #5 clk = ~clk;

  // memory: answers after lat waiting cycles of a continuously held request
  always_comb begin
    imemValid = imemReq && (waitCnt >= lat);
    imemRdata = (imemAddr == J_ADDR) ? J_WORD : imemAddr;
  end

  always @(posedge clk) begin
    if (!imemReq || imemValid) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: each consumed IF/ID instruction is compared against the queue
  always @(negedge clk) begin
    if (monEn && ifidValid && !stall && sbQ.size() > 0) begin
      exp_t e;
      e = sbQ.pop_front();
      check("sbInstr", ifidInstr, e.instr);
      check("sbPcPlus4", ifidPcPlus4, e.pcPlus4);
    end
  end

  task automatic drainSb();
    int n = 0;
    while (sbQ.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() > 0) begin
      nCmp++;
      nFail++;
      $display("FAIL sbTimeout: got %0d pending expected 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  // called at a negedge; returns at the next negedge with FETCH at t pending
  task automatic redirectTo(input logic [31:0] t);
    lat = 0;
    pcSrc = 1'b1;
    branchTarget = t;
    @(negedge clk);
    pcSrc = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0200, 32'h0000_0200, 0, 4};
    vecs[1] = '{32'h0000_0403, 32'h0000_0400, 1, 3};
    vecs[2] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 0, 4};
    vecs[3] = '{32'h0000_1000, 32'h0000_1000, 2, 3};
    vecs[4] = '{32'h0000_0052, 32'h0000_0050, 0, 3};

    rstN = 1'b0; stall = 1'b0; pcSrc = 1'b0; branchTarget = '0;
    repeat (2) @(negedge clk);
    check("rstReq", {31'd0, imemReq}, 32'd0);
    check("rstAddr", imemAddr, 32'h0);
    check("rstInstr", ifidInstr, 32'h0);
    check("rstPcPlus4", ifidPcPlus4, 32'h0);
    check("rstValid", {31'd0, ifidValid}, 32'd0);

    // zero-wait stream from reset
    for (int k = 0; k < 4; k++) sbQ.push_back('{32'(4*k), 32'(4*k+4)});
    monEn = 1'b1;
    rstN = 1'b1;
    #1 check("idleReq", {31'd0, imemReq}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("seqReq", {31'd0, imemReq}, 32'd1);
      check("seqAddr", imemAddr, 32'(4*k));
    end
    drainSb();
    monEn = 1'b0;

    // redirect table: target alignment, latency, PC wrap
    for (int i = 0; i < 5; i++) begin
      sbQ.delete();
      redirectTo(vecs[i].target);
      check("vecAddr", imemAddr, vecs[i].expBase);
      lat = vecs[i].lat;
      for (int k = 0; k < vecs[i].count; k++)
        sbQ.push_back('{vecs[i].expBase + 32'(4*k), vecs[i].expBase + 32'(4*k+4)});
      monEn = 1'b1;
      drainSb();
      monEn = 1'b0;
      @(negedge clk);
    end

    // 3-cycle memory at 0x10
    redirectTo(32'h10);
    lat = 2;
    for (int k = 0; k < 3; k++) begin
      check("latReq", {31'd0, imemReq}, 32'd1);
      check("latAddr", imemAddr, 32'h10);
      check("latValid", {31'd0, ifidValid}, 32'd0);
      @(negedge clk);
    end
    check("latIfValid", {31'd0, ifidValid}, 32'd1);
    check("latIfPc4", ifidPcPlus4, 32'h14);
    check("latIfInstr", ifidInstr, 32'h10);

    // stall across an outstanding fetch of 0x20
    redirectTo(32'h1C);
    @(negedge clk);
    check("stlPre", ifidPcPlus4, 32'h20);
    lat = 1;
    stall = 1'b1;
    @(negedge clk);
    check("stlReqKept", {31'd0, imemReq}, 32'd1);
    check("stlAddrKept", imemAddr, 32'h20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("holdReq", {31'd0, imemReq}, 32'd0);
      check("holdIfPc4", ifidPcPlus4, 32'h20);
      check("holdIfInstr", ifidInstr, 32'h1C);
    end
    stall = 1'b0;
    lat = 0;
    @(negedge clk);
    check("relIfPc4", ifidPcPlus4, 32'h24);
    check("relIfInstr", ifidInstr, 32'h20);
    check("relIfValid", {31'd0, ifidValid}, 32'd1);
    check("relAddr", imemAddr, 32'h24);

    // redirect while memory is waiting on 0x44
    redirectTo(32'h44);
    lat = 2;
    @(negedge clk);
    pcSrc = 1'b1;
    branchTarget = 32'h100;
    @(negedge clk);
    pcSrc = 1'b0;
    check("discReq", {31'd0, imemReq}, 32'd1);
    check("discAddr", imemAddr, 32'h44);
    check("discValid", {31'd0, ifidValid}, 32'd0);
    @(negedge clk);
    check("discDrop", {31'd0, ifidValid}, 32'd0);
    check("discNewAddr", imemAddr, 32'h100);
    lat = 0;
    @(negedge clk);
    check("discIfPc4", ifidPcPlus4, 32'h104);
    check("discIfInstr", ifidInstr, 32'h100);

    // pcSrc masked by stall
    redirectTo(32'h80);
    stall = 1'b1;
    pcSrc = 1'b1;
    branchTarget = 32'h300;
    @(negedge clk);
    check("msHoldReq", {31'd0, imemReq}, 32'd0);
    @(negedge clk);
    stall = 1'b0;
    pcSrc = 1'b0;
    @(negedge clk);
    check("msAddr", imemAddr, 32'h84);
    check("msIfPc4", ifidPcPlus4, 32'h84);

    // j at 0x1000_0004
    redirectTo(J_ADDR);
    @(negedge clk);
    check("jIfInstr", ifidInstr, J_WORD);
    @(negedge clk);
`ifdef JUMP_EN
    check("jAddr", imemAddr, 32'h1000_0100);
    check("jBubble", {31'd0, ifidValid}, 32'd0);
    @(negedge clk);
    check("jIfPc4", ifidPcPlus4, 32'h1000_0104);
`else
    check("jAddr", imemAddr, 32'h1000_000C);
    check("jIfPc4", ifidPcPlus4, 32'h1000_000C);
    check("jIfValid", {31'd0, ifidValid}, 32'd1);
`endif

    // async reset in DISCARD
    redirectTo(32'h60);
    lat = 2;
    @(negedge clk);
    pcSrc = 1'b1;
    branchTarget = 32'h200;
    @(negedge clk);
    pcSrc = 1'b0;
    check("arDiscAddr", imemAddr, 32'h60);
    rstN = 1'b0;
    #1;
    check("arReq", {31'd0, imemReq}, 32'd0);
    check("arAddr", imemAddr, 32'h0);
    check("arValid", {31'd0, ifidValid}, 32'd0);
    check("arInstr", ifidInstr, 32'h0);
    check("arPcPlus4", ifidPcPlus4, 32'h0);
    @(negedge clk);
    lat = 0;
    rstN = 1'b1;
    @(negedge clk);
    check("arRestartAddr", imemAddr, 32'h0);
    check("arRestartReq", {31'd0, imemReq}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
